// File: rtl/fifo_read_ctrl.sv
// Read-side pointer controller for a synchronous FIFO: read pointer, memory read strobe, empty/underflow flags.
// Optional FIFO_RD_OCCUPANCY_EN adds the read_count occupancy output.
module fifo_read_ctrl #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] write_pointer,
  input  logic            read_enable,
  input  logic            flush,
  output logic [SIZE-1:0] read_pointer,
  output logic [SIZE-2:0] read_address,
  output logic            mem_read_enable,
  output logic            read_valid,
  output logic            empty,
`ifdef FIFO_RD_OCCUPANCY_EN
  output logic [SIZE-1:0] read_count,
`endif
  output logic            underflow
);

  logic [SIZE-1:0] read_pointer_q, read_pointer_d;
  logic            read_valid_q, read_valid_d;
  logic            underflow_q, underflow_d;
  logic            accept;

  assign empty  = (read_pointer_q == write_pointer);
  // Reset also blocks the strobe so no memory read is issued in a reset cycle.
  assign accept = read_enable && !empty && !flush && !reset;

  always_comb begin
    read_pointer_d = read_pointer_q;
    read_valid_d   = 1'b0;
    underflow_d    = underflow_q;
    if (flush) begin
      read_pointer_d = write_pointer;
      underflow_d    = 1'b0;
    end else if (accept) begin
      read_pointer_d = read_pointer_q + 1'b1;
      read_valid_d   = 1'b1;
    end else if (read_enable && empty) begin
      underflow_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_pointer_q <= '0;
      read_valid_q   <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      read_pointer_q <= read_pointer_d;
      read_valid_q   <= read_valid_d;
      underflow_q    <= underflow_d;
    end
  end

  assign read_pointer    = read_pointer_q;
  assign read_address    = read_pointer_q[SIZE-2:0];
  assign mem_read_enable = accept;
  assign read_valid      = read_valid_q;
  assign underflow       = underflow_q;

`ifdef FIFO_RD_OCCUPANCY_EN
  assign read_count = write_pointer - read_pointer_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Randomised bench for fifo_read_ctrl: a queue-based FIFO model plus a scoreboard of read data words.
module tb_fifo_read_ctrl;
  localparam int SIZE  = 4;
  localparam int DEPTH = 1 << (SIZE - 1);

  logic            clk = 1'b0;
  logic            reset;
  logic [SIZE-1:0] write_pointer;
  logic            read_enable;
  logic            flush;
  logic [SIZE-1:0] read_pointer;
  logic [SIZE-2:0] read_address;
  logic            mem_read_enable;
  logic            read_valid;
  logic            empty;
  logic            underflow;
`ifdef FIFO_RD_OCCUPANCY_EN
  logic [SIZE-1:0] read_count;
`endif

  fifo_read_ctrl #(.SIZE(SIZE)) dut (
    .clk             (clk),
    .reset           (reset),
    .write_pointer   (write_pointer),
    .read_enable     (read_enable),
    .flush           (flush),
    .read_pointer    (read_pointer),
    .read_address    (read_address),
    .mem_read_enable (mem_read_enable),
    .read_valid      (read_valid),
    .empty           (empty),
`ifdef FIFO_RD_OCCUPANCY_EN
    .read_count      (read_count),
`endif
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  // Memory and write side owned by the bench.
  logic [7:0] tb_mem [DEPTH];
  logic [7:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_data;

  always @(posedge clk) begin
    if (wr_en) tb_mem[write_pointer[SIZE-2:0]] <= wr_data;
    if (mem_read_enable) rd_data <= tb_mem[read_address];
  end

  // Reference model: stored words in order, plus the architectural read pointer.
  logic [7:0]      model_q [$];
  logic [7:0]      exp_q   [$];
  logic [SIZE-1:0] rp_m;
  logic [SIZE-1:0] wp_next;
  logic            uf_m;
  logic            valid_m;
  bit              checking = 0;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each read_valid must deliver the oldest outstanding expected word.
  always begin
    @(negedge clk);
    #1;
    if (checking && read_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rdata_unexpected", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("rdata", {24'd0, rd_data}, {24'd0, e});
        $display("read word %02h expected %02h", rd_data, e);
      end
    end
  end

  initial begin
    int re_pct, we_pct;
    reset = 1'b1; read_enable = 1'b0; flush = 1'b0; write_pointer = '0;
    wr_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read_pointer", {28'd0, read_pointer}, 32'd0);
    chk("rst_read_valid", {31'd0, read_valid}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    rp_m = '0; wp_next = '0; uf_m = 1'b0; valid_m = 1'b0;
    checking = 1;
    re_pct = 70; we_pct = 50;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 80 == 0) begin
        re_pct = $urandom_range(10, 95);
        we_pct = $urandom_range(10, 95);
      end
      write_pointer = wp_next;
      if (cyc >= 2980) begin
        reset = 1'b0; flush = 1'b0; read_enable = 1'b0; wr_en = 1'b0;
      end else begin
        reset       = ($urandom_range(0, 99) < 2);
        flush       = ($urandom_range(0, 99) < 4);
        read_enable = ($urandom_range(0, 99) < re_pct);
        wr_en       = !reset && (model_q.size() < DEPTH) && ($urandom_range(0, 99) < we_pct);
      end
      wr_data = 8'($urandom);

      @(negedge clk);
      chk("read_pointer", {28'd0, read_pointer}, {28'd0, rp_m});
      chk("read_address", {29'd0, read_address}, {29'd0, rp_m[SIZE-2:0]});
      chk("empty", {31'd0, empty}, {31'd0, model_q.size() == 0});
      chk("read_valid", {31'd0, read_valid}, {31'd0, valid_m});
      chk("underflow", {31'd0, underflow}, {31'd0, uf_m});
`ifdef FIFO_RD_OCCUPANCY_EN
      chk("read_count", {28'd0, read_count}, model_q.size());
`endif
      if (!reset)
        chk("mem_read_enable", {31'd0, mem_read_enable},
            {31'd0, read_enable && !flush && model_q.size() != 0});

      if (reset) begin
        model_q.delete();
        rp_m = '0; wp_next = '0; uf_m = 1'b0; valid_m = 1'b0;
      end else begin
        if (flush) begin
          model_q.delete();
          rp_m = write_pointer; uf_m = 1'b0; valid_m = 1'b0;
        end else if (read_enable && model_q.size() != 0) begin
          exp_q.push_back(model_q.pop_front());
          rp_m = rp_m + 1'b1; valid_m = 1'b1;
        end else begin
          valid_m = 1'b0;
          if (read_enable) uf_m = 1'b1;
        end
        if (wr_en) begin
          model_q.push_back(wr_data);
          wp_next = write_pointer + 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
